gnrl_fifo: RTL and testbench
============================

GNRL_FIFO -- requirements
Module: gnrl_fifo

Interface
REQ-001 The block SHALL have parameter DW, default 32, meaning the data width in bits (DW >= 1).
REQ-002 The block SHALL have parameter DP, default 4, meaning the depth in entries (DP >= 1; non-power-of-two allowed).
REQ-003 The block SHALL have parameter CUT_READY, default 0, meaning i_rdy has no combinational path from o_rdy when set to 1.
REQ-004 The block SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port flush, input, 1 bit: synchronous discard of all stored entries.
REQ-007 The block SHALL have port i_vld, input, 1 bit: writer offers i_dat.
REQ-008 The block SHALL have port i_rdy, output, 1 bit: FIFO accepts the offered word.
REQ-009 The block SHALL have port i_dat, input, DW bits: write data.
REQ-010 The block SHALL have port o_vld, output, 1 bit: head entry is available.
REQ-011 The block SHALL have port o_rdy, input, 1 bit: reader consumes the head entry.
REQ-012 The block SHALL have port o_dat, output, DW bits: head entry data.
REQ-013 The block SHALL have port o_cnt, output, clog2(DP+1) bits: number of stored entries.

Function
REQ-014 The block SHALL define push = i_vld & i_rdy and pop = o_vld & o_rdy, both evaluated in the same cycle.
REQ-015 Storage SHALL be DP entries of DW bits, written only on push, with no reset on data entries; write pointer, read pointer and count SHALL be reset.
REQ-016 On push, the block SHALL write i_dat to entry wptr, and wptr SHALL advance by 1, wrapping from DP-1 to 0.
REQ-017 On pop, rptr SHALL advance by 1, wrapping from DP-1 to 0.
REQ-018 Count update SHALL be: push-only +1, pop-only -1, push&pop unchanged, neither unchanged.
REQ-019 The block SHALL assert o_vld = (count != 0) and drive o_dat = entry[rptr]; o_dat is don't-care when o_vld = 0.
REQ-020 Latency SHALL be 1 cycle: a word pushed at edge N appears on o_vld/o_dat after edge N when the FIFO was empty; there is no same-cycle bypass.
REQ-021 With CUT_READY = 1, i_rdy SHALL be (count != DP) & ~flush.
REQ-022 With CUT_READY = 0, i_rdy SHALL be ((count != DP) | o_rdy) & ~flush, so that a full FIFO accepts a push in the same cycle as a pop.
REQ-023 When empty, a pop SHALL be impossible (o_vld = 0), so push with o_rdy = 1 SHALL give count = 1.
REQ-024 When full, a push without a pop SHALL be impossible (i_rdy = 0), so count SHALL never exceed DP.
REQ-025 For DP = 1, the block SHALL behave as a single-entry stage with pointers held at 0 and count in {0,1}.
REQ-026 flush SHALL have priority over push and pop: at the next edge, count = 0 and wptr = rptr = 0.
REQ-027 While flush = 1, the block SHALL hold o_vld unchanged (flush takes effect at the edge) and force i_rdy to 0.
REQ-028 o_cnt SHALL equal count with no additional latency.
REQ-029 Simulation-only assertions SHALL flag X on i_vld, o_rdy or flush after reset release.
REQ-030 Simulation-only assertions SHALL flag count > DP.

Reset
REQ-031 Asserting rst_n low at any time, including mid-transfer, SHALL immediately force count = 0, wptr = rptr = 0, o_vld = 0 and o_cnt = 0.
REQ-032 During reset, i_rdy SHALL equal its empty-state value (1 when flush = 0).
REQ-033 The first push SHALL be accepted at the first rising edge after rst_n deasserts.

Verification (DW=8, DP=4 unless stated)
REQ-034 Push 0x11,0x22,0x33,0x44 with o_rdy=0 -> o_cnt=4, i_rdy=0 (CUT_READY=1), o_dat=0x11.
REQ-035 Full FIFO, CUT_READY=0, i_vld=1 i_dat=0x55 with o_rdy=1 -> 0x11 popped and 0x55 accepted in the same cycle; o_cnt stays 4; read order is 0x22,0x33,0x44,0x55.
REQ-036 Push 6 words and pop 6 words interleaved (DP=3) -> pointers wrap twice, data order preserved, o_cnt returns to 0, o_vld=0.
REQ-037 Three words stored, flush=1 for one cycle with i_vld=1 -> next cycle o_cnt=0, o_vld=0, and the offered word is not stored.
REQ-038 rst_n pulsed low while o_cnt=2 and push active -> o_vld=0 and o_cnt=0 asynchronously; after release, push 0xA5 -> o_dat=0xA5 one cycle later.
REQ-039 DP=1, streaming with o_rdy=1 and CUT_READY=0 -> one word per cycle throughput; with CUT_READY=1 -> one word per two cycles.

Source files
------------

// File: rtl/gnrl_fifo.sv
// gnrl_fifo: synchronous FIFO with flush, any depth, optional ready-path cut.
// o_dat shows the entry at the read pointer. There is no bypass, so a word written into an empty FIFO appears one cycle later.
module gnrl_fifo #(
  parameter int DW = 32,
  parameter int DP = 4,
  parameter int CUT_READY = 0
)(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       i_vld,
  output logic                       i_rdy,
  input  logic [DW-1:0]              i_dat,
  output logic                       o_vld,
  input  logic                       o_rdy,
  output logic [DW-1:0]              o_dat,
  output logic [$clog2(DP+1)-1:0]    o_cnt
);
  localparam int PW = DP > 1 ? $clog2(DP) : 1;
  localparam int CW = $clog2(DP+1);
  localparam logic [PW-1:0] LP_PLAST = PW'(DP-1);
  localparam logic [CW-1:0] LP_FULL = CW'(DP);
  logic [DW-1:0] r_mem [DP];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_cnt;
  logic w_push, w_pop, w_full;
  assign w_full = r_cnt == LP_FULL;
  // Without the cut, a full FIFO still accepts a word when the head leaves in the same cycle.
  assign i_rdy  = (~w_full | ((CUT_READY == 0) & o_rdy)) & ~flush;
  assign o_vld  = r_cnt != '0;
  assign o_dat  = r_mem[r_rptr];
  assign o_cnt  = r_cnt;
  assign w_push = i_vld & i_rdy;
  assign w_pop  = o_vld & o_rdy;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else if (flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr == LP_PLAST ? '0 : r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr == LP_PLAST ? '0 : r_rptr + 1'b1;
      if (w_push != w_pop) r_cnt <= w_push ? r_cnt + 1'b1 : r_cnt - 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_dat;
  end
`ifndef SYNTHESIS
  a_known: assert property (@(posedge clk) disable iff (!rst_n) !$isunknown({i_vld, o_rdy, flush}));
  a_cnt: assert property (@(posedge clk) disable iff (!rst_n) r_cnt <= LP_FULL);
`endif
endmodule

// File: tb/tb_gnrl_fifo.sv
// tb_gnrl_fifo: directed checks of gnrl_fifo across depth and ready-cut variants.
// All instances share the same stimulus. Each scenario checks only the instance it targets.
module tb_gnrl_fifo;
  logic clk, rst_n, flush, i_vld, o_rdy;
  logic [7:0] i_dat;
  logic r4c_ir, r4c_ov, r4_ir, r4_ov, r3_ir, r3_ov, r1a_ir, r1a_ov, r1b_ir, r1b_ov;
  logic [7:0] r4c_od, r4_od, r3_od, r1a_od, r1b_od;
  logic [2:0] r4c_cnt, r4_cnt;
  logic [1:0] r3_cnt;
  logic r1a_cnt, r1b_cnt;
  int n_pass, n_total;

  gnrl_fifo #(.DW(8), .DP(4), .CUT_READY(1)) u4c (.clk(clk), .rst_n(rst_n), .flush(flush), .i_vld(i_vld),
    .i_rdy(r4c_ir), .i_dat(i_dat), .o_vld(r4c_ov), .o_rdy(o_rdy), .o_dat(r4c_od), .o_cnt(r4c_cnt));
  gnrl_fifo #(.DW(8), .DP(4), .CUT_READY(0)) u4 (.clk(clk), .rst_n(rst_n), .flush(flush), .i_vld(i_vld),
    .i_rdy(r4_ir), .i_dat(i_dat), .o_vld(r4_ov), .o_rdy(o_rdy), .o_dat(r4_od), .o_cnt(r4_cnt));
  gnrl_fifo #(.DW(8), .DP(3), .CUT_READY(0)) u3 (.clk(clk), .rst_n(rst_n), .flush(flush), .i_vld(i_vld),
    .i_rdy(r3_ir), .i_dat(i_dat), .o_vld(r3_ov), .o_rdy(o_rdy), .o_dat(r3_od), .o_cnt(r3_cnt));
  gnrl_fifo #(.DW(8), .DP(1), .CUT_READY(0)) u1a (.clk(clk), .rst_n(rst_n), .flush(flush), .i_vld(i_vld),
    .i_rdy(r1a_ir), .i_dat(i_dat), .o_vld(r1a_ov), .o_rdy(o_rdy), .o_dat(r1a_od), .o_cnt(r1a_cnt));
  gnrl_fifo #(.DW(8), .DP(1), .CUT_READY(1)) u1b (.clk(clk), .rst_n(rst_n), .flush(flush), .i_vld(i_vld),
    .i_rdy(r1b_ir), .i_dat(i_dat), .o_vld(r1b_ov), .o_rdy(o_rdy), .o_dat(r1b_od), .o_cnt(r1b_cnt));

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 0; i_vld = 0; o_rdy = 0; flush = 0; i_dat = 0;
    tick;
    rst_n = 1;
  endtask

  task automatic test_reset;
    rst_n = 0; i_vld = 0; o_rdy = 0; flush = 0; i_dat = 0;
    #1;
    n_total++; if (r4c_ov !== 1'b0) $display("FAIL reset_ovld: got %b want 0", r4c_ov); else n_pass++;
    n_total++; if (r4c_cnt !== 3'd0) $display("FAIL reset_cnt: got %0d want 0", r4c_cnt); else n_pass++;
    n_total++; if (r4c_ir !== 1'b1) $display("FAIL reset_irdy: got %b want 1", r4c_ir); else n_pass++;
    tick;
    rst_n = 1;
  endtask

  task automatic test_fill;
    do_reset;
    i_vld = 1; i_dat = 8'h11;
    n_total++; if (r4c_ov !== 1'b0) $display("FAIL fill_nobypass: got %b want 0", r4c_ov); else n_pass++;
    tick;
    n_total++; if (r4c_ov !== 1'b1 || r4c_od !== 8'h11) $display("FAIL fill_latency: got vld=%b dat=%h want 1/11", r4c_ov, r4c_od); else n_pass++;
    for (int k = 2; k <= 4; k++) begin
      i_dat = 8'(8'h11 * k);
      tick;
    end
    i_vld = 0;
    n_total++; if (r4c_cnt !== 3'd4) $display("FAIL fill_cnt: got %0d want 4", r4c_cnt); else n_pass++;
    n_total++; if (r4c_ir !== 1'b0) $display("FAIL fill_irdy_full: got %b want 0", r4c_ir); else n_pass++;
    n_total++; if (r4c_od !== 8'h11) $display("FAIL fill_head: got %h want 11", r4c_od); else n_pass++;
    n_total++; if (r4_ir !== 1'b0) $display("FAIL fill_irdy_nocut_ordy0: got %b want 0", r4_ir); else n_pass++;
    o_rdy = 1;
    #1;
    n_total++; if (r4_ir !== 1'b1) $display("FAIL fill_irdy_nocut_ordy1: got %b want 1", r4_ir); else n_pass++;
    n_total++; if (r4c_ir !== 1'b0) $display("FAIL fill_irdy_cut_ordy1: got %b want 0", r4c_ir); else n_pass++;
  endtask

  task automatic test_full_pushpop;
    logic [7:0] exp_d [4];
    exp_d = '{8'h22, 8'h33, 8'h44, 8'h55};
    i_vld = 1; i_dat = 8'h55; o_rdy = 1;
    tick;
    i_vld = 0;
    n_total++; if (r4_cnt !== 3'd4) $display("FAIL pushpop_cnt: got %0d want 4", r4_cnt); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_total++; if (r4_od !== exp_d[k]) $display("FAIL pushpop_order%0d: got %h want %h", k, r4_od, exp_d[k]); else n_pass++;
      tick;
    end
    n_total++; if (r4_cnt !== 3'd0 || r4_ov !== 1'b0) $display("FAIL pushpop_drain: got cnt=%0d vld=%b want 0/0", r4_cnt, r4_ov); else n_pass++;
  endtask

  task automatic test_wrap;
    logic [7:0] w;
    do_reset;
    i_vld = 1; i_dat = 8'hA0;
    tick;
    o_rdy = 1;
    for (int k = 1; k <= 5; k++) begin
      w = 8'(8'hA0 + k);
      i_dat = w;
      n_total++; if (r3_od !== w - 8'd1) $display("FAIL wrap_dat%0d: got %h want %h", k, r3_od, w - 8'd1); else n_pass++;
      tick;
      n_total++; if (r3_cnt !== 2'd1) $display("FAIL wrap_cnt%0d: got %0d want 1", k, r3_cnt); else n_pass++;
    end
    i_vld = 0;
    n_total++; if (r3_od !== 8'hA5) $display("FAIL wrap_last: got %h want a5", r3_od); else n_pass++;
    tick;
    n_total++; if (r3_cnt !== 2'd0 || r3_ov !== 1'b0) $display("FAIL wrap_empty: got cnt=%0d vld=%b want 0/0", r3_cnt, r3_ov); else n_pass++;
  endtask

  task automatic test_flush;
    do_reset;
    i_vld = 1;
    for (int k = 1; k <= 3; k++) begin
      i_dat = 8'(8'h11 * k);
      tick;
    end
    flush = 1; i_dat = 8'h99;
    #1;
    n_total++; if (r4c_ir !== 1'b0) $display("FAIL flush_irdy: got %b want 0", r4c_ir); else n_pass++;
    n_total++; if (r4c_ov !== 1'b1 || r4c_cnt !== 3'd3) $display("FAIL flush_hold: got vld=%b cnt=%0d want 1/3", r4c_ov, r4c_cnt); else n_pass++;
    tick;
    flush = 0; i_vld = 0;
    n_total++; if (r4c_cnt !== 3'd0 || r4c_ov !== 1'b0) $display("FAIL flush_clear: got cnt=%0d vld=%b want 0/0", r4c_cnt, r4c_ov); else n_pass++;
    i_vld = 1; i_dat = 8'h77;
    tick;
    i_vld = 0;
    n_total++; if (r4c_od !== 8'h77 || r4c_cnt !== 3'd1) $display("FAIL flush_after: got dat=%h cnt=%0d want 77/1", r4c_od, r4c_cnt); else n_pass++;
  endtask

  task automatic test_async_reset;
    do_reset;
    i_vld = 1; i_dat = 8'h31;
    tick;
    i_dat = 8'h32;
    tick;
    n_total++; if (r4_cnt !== 3'd2) $display("FAIL arst_pre: got %0d want 2", r4_cnt); else n_pass++;
    #2 rst_n = 0;
    #1;
    n_total++; if (r4_ov !== 1'b0 || r4_cnt !== 3'd0) $display("FAIL arst_async: got vld=%b cnt=%0d want 0/0", r4_ov, r4_cnt); else n_pass++;
    n_total++; if (r4_ir !== 1'b1) $display("FAIL arst_irdy: got %b want 1", r4_ir); else n_pass++;
    #1 rst_n = 1;
    i_dat = 8'hA5;
    tick;
    i_vld = 0;
    n_total++; if (r4_ov !== 1'b1 || r4_od !== 8'hA5 || r4_cnt !== 3'd1) $display("FAIL arst_first: got vld=%b dat=%h cnt=%0d want 1/a5/1", r4_ov, r4_od, r4_cnt); else n_pass++;
  endtask

  task automatic test_dp1_stream;
    int na, nb;
    logic [7:0] w;
    na = 0; nb = 0;
    do_reset;
    i_vld = 1; o_rdy = 1;
    for (int k = 0; k < 8; k++) begin
      w = 8'(8'hC0 + k);
      i_dat = w;
      #1;
      na += int'(r1a_ir);
      nb += int'(r1b_ir);
      tick;
      n_total++; if (r1a_od !== w) $display("FAIL dp1_dat%0d: got %h want %h", k, r1a_od, w); else n_pass++;
    end
    i_vld = 0;
    n_total++; if (na !== 8) $display("FAIL dp1_nocut_rate: got %0d want 8", na); else n_pass++;
    n_total++; if (nb !== 4) $display("FAIL dp1_cut_rate: got %0d want 4", nb); else n_pass++;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst_n = 0; flush = 0; i_vld = 0; o_rdy = 0; i_dat = 0;
    test_reset;
    test_fill;
    test_full_pushpop;
    test_wrap;
    test_flush;
    test_async_reset;
    test_dp1_stream;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
